// File: rtl/led_seq_ctrl.sv
// LED running-light pattern sequencer: prescaled step rate, mode-selected patterns.
// Optional ping-pong pattern family is built only when LED_SEQ_PINGPONG_EN is defined.
module led_seq_ctrl #(
  parameter int TICK_DIV = 12_500_000,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [1:0] mode,
  input  logic [1:0] speed,
  output logic [7:0] led,
  output logic       step,
  output logic [2:0] dbg_state
);

`ifdef LED_SEQ_PINGPONG_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEFT    = 3'd1,
    S_RIGHT   = 3'd2,
    S_PP_UP   = 3'd3,
    S_PP_DOWN = 3'd4,
    S_BLINK   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEFT  = 3'd1,
    S_RIGHT = 3'd2,
    S_BLINK = 3'd5
  } state_t;
`endif

  typedef enum logic [1:0] {
    F_LEFT  = 2'd0,
    F_RIGHT = 2'd1,
    F_PP    = 2'd2,
    F_BLINK = 2'd3
  } family_t;

  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [7:0]       led_q, led_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic [2:0]       sub_q, sub_d;

  logic       tick;
  logic       step_en;
  logic [2:0] sub_lim;
  family_t    cur_fam;
  family_t    tgt_fam;

  // Handshake-free block: inputs are levels, step is a one-cycle strobe aligned with led.
  always_comb begin
    case (speed)
      2'd0:    sub_lim = 3'd0;
      2'd1:    sub_lim = 3'd1;
      2'd2:    sub_lim = 3'd3;
      default: sub_lim = 3'd7;
    endcase
  end

  always_comb begin
    tgt_fam = F_LEFT;
    case (mode)
      2'b00: tgt_fam = F_LEFT;
      2'b01: tgt_fam = F_RIGHT;
`ifdef LED_SEQ_PINGPONG_EN
      2'b10: tgt_fam = F_PP;
`else
      2'b10: tgt_fam = F_LEFT;
`endif
      default: tgt_fam = F_BLINK;
    endcase
  end

  always_comb begin
    cur_fam = F_LEFT;
    case (state_q)
      S_RIGHT:   cur_fam = F_RIGHT;
`ifdef LED_SEQ_PINGPONG_EN
      S_PP_UP:   cur_fam = F_PP;
      S_PP_DOWN: cur_fam = F_PP;
`endif
      S_BLINK:   cur_fam = F_BLINK;
      default:   cur_fam = F_LEFT;
    endcase
  end

  // Prescaler and sub-counter only advance while run is high; both freeze otherwise.
  always_comb begin
    pre_d   = pre_q;
    sub_d   = sub_q;
    tick    = run && (pre_q == PRE_MAX);
    step_en = 1'b0;
    if (run) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + CNT_W'(1);
    end
    if (tick) begin
      if (sub_q >= sub_lim) begin
        step_en = 1'b1;
        sub_d   = 3'd0;
      end else begin
        sub_d = sub_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    step_d  = step_en;
    if (step_en) begin
      if (state_q == S_IDLE || cur_fam != tgt_fam) begin
        // A family change spends this step on loading the start pattern.
        case (tgt_fam)
          F_RIGHT: begin
            state_d = S_RIGHT;
            led_d   = 8'h80;
          end
`ifdef LED_SEQ_PINGPONG_EN
          F_PP: begin
            state_d = S_PP_UP;
            led_d   = 8'h01;
          end
`endif
          F_BLINK: begin
            state_d = S_BLINK;
            led_d   = 8'hFF;
          end
          default: begin
            state_d = S_LEFT;
            led_d   = 8'h01;
          end
        endcase
      end else begin
        case (state_q)
          S_LEFT:  led_d = {led_q[6:0], led_q[7]};
          S_RIGHT: led_d = {led_q[0], led_q[7:1]};
`ifdef LED_SEQ_PINGPONG_EN
          S_PP_UP: begin
            led_d = {led_q[6:0], 1'b0};
            if (led_d == 8'h80) state_d = S_PP_DOWN;
          end
          S_PP_DOWN: begin
            led_d = {1'b0, led_q[7:1]};
            if (led_d == 8'h01) state_d = S_PP_UP;
          end
`endif
          S_BLINK: led_d = ~led_q;
          default: led_d = led_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      led_q   <= 8'h01;
      step_q  <= 1'b0;
      pre_q   <= '0;
      sub_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      sub_q   <= sub_d;
    end
  end

  assign led       = led_q;
  assign step      = step_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed + randomized bench for led_seq_ctrl against a pattern-index reference model.
// Works with or without LED_SEQ_PINGPONG_EN; the model follows the same define.
module tb_led_seq_ctrl;
  localparam int TD = 4;
  localparam logic [2:0] IDLE_CODE = 3'd0;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [7:0] led;
  logic       step;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // reference model state
  int         m_pre, m_sub, m_fam, m_idx;
  bit         m_started;
  logic [7:0] e_led;
  logic       e_step;
  logic [7:0] pp_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                              8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  led_seq_ctrl #(.TICK_DIV(TD), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .mode(mode), .speed(speed),
    .led(led), .step(step), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int fam_of(input logic [1:0] m);
`ifdef LED_SEQ_PINGPONG_EN
    return int'(m);
`else
    return (m == 2'b10) ? 0 : int'(m);
`endif
  endfunction

  function automatic logic [7:0] pattern(input int fam, input int idx);
    logic [7:0] one;
    one = 8'h01;
    case (fam)
      0:       return one << (idx % 8);
      1:       return 8'h80 >> (idx % 8);
      2:       return pp_tab[idx % 14];
      default: return (idx % 2 == 1) ? 8'h00 : 8'hFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare after the edge.
  task automatic cyc();
    int lim;
    if (rst) begin
      m_pre = 0; m_sub = 0; m_started = 0; m_idx = 0; m_fam = 0;
      e_led = 8'h01; e_step = 1'b0;
    end else begin
      e_step = 1'b0;
      if (run) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          lim = (1 << speed) - 1;
          if (m_sub >= lim) begin
            m_sub  = 0;
            e_step = 1'b1;
            if (!m_started || fam_of(mode) != m_fam) begin
              m_started = 1;
              m_fam = fam_of(mode);
              m_idx = 0;
            end else begin
              m_idx++;
            end
            e_led = pattern(m_fam, m_idx);
          end else begin
            m_sub++;
          end
        end else begin
          m_pre++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    chk("led", 32'(led), 32'(e_led));
    chk("step", 32'(step), 32'(e_step));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_step(input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < limit);
    chk("step_within_bound", 32'(step), 32'd1);
  endtask

  initial begin
    int n;
    int t0;
    rst = 1'b1; run = 1'b0; mode = 2'b00; speed = 2'd0;

    // 1: reset then idle with run low
    cycles(2);
    chk("reset_state", 32'(dbg_state), 32'(IDLE_CODE));
    rst = 1'b0;
    cycles(12);
    chk("idle_state_hold", 32'(dbg_state), 32'(IDLE_CODE));

    // 2: rotate left, first reload step lands TICK_DIV cycles after run rises
    run = 1'b1;
    wait_step(20, n);
    chk("first_step_latency", 32'(n), 32'(TD));
    chk("first_step_led", 32'(led), 32'h01);
    cycles(TD * 10);

    // 3: rotate right; mode toggles between steps must not disturb anything
    mode = 2'b01;
    cycles(TD * 3);
    for (int i = 0; i < TD * 12; i++) begin
      if (i % TD == 1) mode = 2'($urandom_range(0, 1));
      if (i % TD == 3) mode = 2'b01;
      cyc();
    end

    // 4: ping-pong (rotate left when the feature is absent)
    mode = 2'b10;
    cycles(TD * 30);

    // 5: slow speed, pause mid-interval, reset mid-run
    speed = 2'd3;
    wait_step(80, n);
    t0 = cyc_n;
    wait_step(40, n);
    chk("speed3_interval", 32'(cyc_n - t0), 32'(TD * 8));
    t0 = cyc_n;
    cycles(13);
    run = 1'b0;
    cycles(10);
    run = 1'b1;
    wait_step(60, n);
    chk("paused_interval", 32'(cyc_n - t0), 32'(TD * 8 + 10));
    cycles(7);
    rst = 1'b1;
    cyc();
    chk("midrun_reset_state", 32'(dbg_state), 32'(IDLE_CODE));
    rst = 1'b0;
    speed = 2'd0;

    // 6: blink, then left again
    mode = 2'b11;
    cycles(TD * 6);
    mode = 2'b00;
    cycles(TD * 4);

    // randomized soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) run = ~run;
      rst = ($urandom_range(0, 250) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Pattern sequencer for the 8-bit LED running-light bank. Divides the board clock into a step rate, runs a small state machine selected by a mode input, and drives the `led` bus with rotate-left, rotate-right, ping-pong or blink patterns. It replaces free-running per-clock rotation with a controlled, pausable, speed-selectable sequence. It sits between the board clock/switch inputs and the LED pins.

## Interface

- `TICK_DIV`, default 12_500_000: clocks per base tick; must be ≥ 2.
- `CNT_W`, default 24: prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV.
- `clk` in 1: board clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: 1 = sequence advances; 0 = hold pattern and prescaler.
- `mode` in 2: 00 rotate left, 01 rotate right, 10 ping-pong, 11 blink.
- `speed` in 2: step every 2^speed base ticks (1, 2, 4, 8).
- `led` out 8: registered LED pattern.
- `step` out 1: one-cycle pulse, high in the cycle `led` takes a new value.

## Operation

- Prescaler `pre`: counts 0..TICK_DIV-1 while `run`=1 and wraps to 0. `tick` = `run` & (`pre`==TICK_DIV-1). While `run`=0, `pre` holds its value and is not cleared.
- Sub-counter `sub` (3 bits): on `tick`, if `sub` ≥ 2^speed−1 then `step_en`=1 and `sub`←0; otherwise `sub`←`sub`+1. A lowered `speed` therefore steps on the next tick.
- FSM states:
  - IDLE: after reset.
  - LEFT
  - RIGHT
  - PP_UP
  - PP_DOWN
  - BLINK
- `mode` is sampled only on `step_en`.
- Reload rule: on `step_en` from IDLE, or when the sampled `mode` selects a different state family than the current one, the step is a reload. The step is consumed by the load. Reload values:
  - LEFT: 8'h01
  - RIGHT: 8'h80
  - PP_UP: 8'h01
  - BLINK: 8'hFF
- LEFT: `led` ← {led[6:0], led[7]}. 8'h80 wraps to 8'h01.
- RIGHT: `led` ← {led[0], led[7:1]}. 8'h01 wraps to 8'h80.
- PP_UP: shift left.
  - When the result is 8'h80, the next state is PP_DOWN.
  - PP_DOWN shifts right; when the result is 8'h01, the next state is PP_UP.
  - Each end LED is lit for exactly one step. Full period is 14 steps.
- BLINK: `led` ← ~`led`, alternating 8'hFF and 8'h00.
- Exactly one bit of `led` is set in every state except BLINK and at reset.

## Timing

- Reset values: `led`=8'h01, `step`=0, state=IDLE, `pre`=0, `sub`=0. `rst` overrides `run` and all other inputs, including mid-step.
- `led` and `step` update on the same rising edge. `step` is high for exactly one clock.
- First step after `run` rises from reset takes TICK_DIV×2^speed cycles. Subsequent steps follow at the same interval while `speed` is constant.
- `run` falling on a `tick` cycle: no tick is generated, because `run` gates the tick. Pattern, `pre` and `sub` freeze and resume where they stopped.
- A `mode` change takes effect only at the next `step_en`; between steps it has no effect.
- No combinational path from inputs to outputs.

## Configuration

- `LED_SEQ_PINGPONG_EN` defined: PP_UP/PP_DOWN states are present and `mode`=10 selects ping-pong.
- Not defined: the ping-pong states and their logic are removed, and `mode`=10 behaves exactly as 00 (rotate left, same reload and sequence).

## Test plan

Scenarios 1–5 use `TICK_DIV`=4 with `LED_SEQ_PINGPONG_EN` defined.

1. Hold `rst`=1 for 2 cycles, then release with `run`=0 → `led`=8'h01 and `step`=0 indefinitely.
2. `run`=1, `mode`=00, `speed`=0 → first step (reload) gives 8'h01 at cycle 4. Then 02, 04 … 80, 01, each 4 cycles apart, with one `step` pulse per change.
3. `mode`=01 mid-sequence → next step reloads 8'h80, then 40, 20 …, wrapping 01→80. Toggling `mode` between steps causes no change.
4. `mode`=10 → 01, 02 … 80, 40 … 02, 01, 02; 14-step period, with no repeated 80 or 01.
5. `speed`=3 → 32 cycles between steps. Drop `run` for 10 cycles mid-interval → the step is delayed by exactly 10 cycles. Assert `rst` mid-run → 8'h01 and IDLE on the next edge.
6. Without the macro, `mode`=10 → identical trace to `mode`=00. `mode`=11 → FF, 00, FF at step intervals.
